// File: rtl/wb_bus_watchdog.sv
// -----------------------------------------------------------------------------
// wb_bus_watchdog
//
// Purpose:
//   Sits between the Caravel Wishbone master and the user-area interconnect.
//   Transactions pass through combinationally. If the addressed slave does not
//   ack within TIMEOUT_CYCLES strobe cycles, the watchdog terminates the cycle
//   itself with an ack carrying ERR_DATA, so a dead or unmapped slot cannot
//   hang the management core. The failing address/we are recorded, a
//   saturating timeout count is kept and a sticky interrupt is raised.
//
// Optional feature (macro WB_WDOG_LATE_ACK_CNT_EN):
//   When defined, adds late_ack_cnt_o, a saturating count of slave acks that
//   arrive after the watchdog has already terminated the cycle. When
//   undefined, such late acks are silently discarded.
//
// Ports:
//   wb_clk_i        in   Wishbone clock
//   wb_rst_ni       in   asynchronous active-low reset
//   wbs_stb_i       in   master strobe
//   wbs_cyc_i       in   master cycle
//   wbs_we_i        in   master write enable (captured on timeout only)
//   wbs_adr_i       in   master address [31:0]
//   wbs_ack_o       out  ack to master
//   wbs_dat_o       out  read data to master [31:0]
//   slv_stb_o       out  strobe to interconnect
//   slv_ack_i       in   ack from interconnect
//   slv_dat_i       in   read data from interconnect [31:0]
//   clr_i           in   synchronous clear of irq and counts
//   late_ack_cnt_o  out  late-ack count [7:0] (only with the macro defined)
//   timeout_irq_o   out  sticky timeout flag
//   timeout_cnt_o   out  saturating timeout count [7:0]
//   last_err_adr_o  out  address of most recent timed-out access [31:0]
//   last_err_we_o   out  we of most recent timed-out access
// -----------------------------------------------------------------------------
module wb_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        slv_stb_o,
    input  logic        slv_ack_i,
    input  logic [31:0] slv_dat_i,
    input  logic        clr_i,
`ifdef WB_WDOG_LATE_ACK_CNT_EN
    output logic [7:0]  late_ack_cnt_o,
`endif
    output logic        timeout_irq_o,
    output logic [7:0]  timeout_cnt_o,
    output logic [31:0] last_err_adr_o,
    output logic        last_err_we_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR_ACK,
        ST_DRAIN
    } state_t;

    localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W:0]   wait_cnt_inc;
    logic             req;
    logic             err_exit;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign req          = wbs_stb_i & wbs_cyc_i;
    assign wait_cnt_inc = {1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // wait_cnt holds the number of completed unacked cycles of the current
    // transaction, so the first strobe cycle (spent in IDLE) counts as 1 on
    // entry to WAIT. Reaching TIMEOUT_CYCLES at the end of a cycle means the
    // error ack lands on strobe cycle TIMEOUT_CYCLES+1, while a slave ack in
    // that same last cycle still wins.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        slv_stb_o    = 1'b0;
        wbs_ack_o    = 1'b0;
        wbs_dat_o    = '0;
        err_exit     = 1'b0;
        // Pass-through paths are gated so all outputs read 0 while in reset.
        if (wb_rst_ni) begin
            case (state)
                ST_IDLE: begin
                    slv_stb_o = req;
                    wbs_ack_o = slv_ack_i;
                    wbs_dat_o = slv_dat_i;
                    if (req && !slv_ack_i) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_WAIT: begin
                    slv_stb_o = req;
                    wbs_ack_o = slv_ack_i;
                    wbs_dat_o = slv_dat_i;
                    if (slv_ack_i || !wbs_cyc_i) begin
                        state_nxt    = ST_IDLE;
                        wait_cnt_nxt = '0;
                    end else if (wait_cnt_inc >= TIMEOUT_LIM) begin
                        state_nxt    = ST_ERR_ACK;
                        wait_cnt_nxt = '0;
                    end else begin
                        wait_cnt_nxt = wait_cnt_inc[CNT_W-1:0];
                    end
                end
                ST_ERR_ACK: begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = ERR_DATA;
                    err_exit  = 1'b1;
                    state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Hold off the slave until the master releases the bus;
                    // any late slave ack is swallowed here.
                    if (!req) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end
            endcase
        end
    end

    // A timeout in the same cycle as clr_i takes priority over the clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            timeout_irq_o  <= 1'b0;
            timeout_cnt_o  <= '0;
            last_err_adr_o <= '0;
            last_err_we_o  <= 1'b0;
        end else if (err_exit) begin
            timeout_irq_o  <= 1'b1;
            timeout_cnt_o  <= clr_i ? 8'd1 : sat_inc8(timeout_cnt_o);
            last_err_adr_o <= wbs_adr_i;
            last_err_we_o  <= wbs_we_i;
        end else if (clr_i) begin
            timeout_irq_o  <= 1'b0;
            timeout_cnt_o  <= '0;
        end
    end

`ifdef WB_WDOG_LATE_ACK_CNT_EN
    logic late_ack_hit;

    assign late_ack_hit = (state == ST_DRAIN) && slv_ack_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            late_ack_cnt_o <= '0;
        end else if (late_ack_hit) begin
            late_ack_cnt_o <= clr_i ? 8'd1 : sat_inc8(late_ack_cnt_o);
        end else if (clr_i) begin
            late_ack_cnt_o <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_bus_watchdog.sv
// -----------------------------------------------------------------------------
// tb_wb_bus_watchdog
//
// Directed bench for wb_bus_watchdog with TIMEOUT_CYCLES=4. A behavioural
// model tracks, per transaction, how many cycles have gone by unacked and
// whether the bus is blocked after an error ack; the expected outputs follow
// from those. Every cycle is checked against the model, and literal values
// worked out by hand pin the model at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_wb_bus_watchdog;

    localparam int          TO   = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we, sack, clr;
    logic [31:0] adr, sdat;
    logic        wbs_ack_o, slv_stb_o, timeout_irq_o, last_err_we_o;
    logic [31:0] wbs_dat_o, last_err_adr_o;
    logic [7:0]  timeout_cnt_o;
`ifdef WB_WDOG_LATE_ACK_CNT_EN
    logic [7:0]  late_ack_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int          run;      // cycles of the current transaction gone unacked
    bit          blocked;  // after the error ack, until the master drops req
    logic [7:0]  m_cnt;
    logic [7:0]  m_late;
    bit          m_irq;
    logic [31:0] m_adr;
    bit          m_we;

    always #5 clk = ~clk;

    wb_bus_watchdog #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (16),
        .ERR_DATA      (ERRD)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_adr_i     (adr),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .slv_stb_o     (slv_stb_o),
        .slv_ack_i     (sack),
        .slv_dat_i     (sdat),
        .clr_i         (clr),
`ifdef WB_WDOG_LATE_ACK_CNT_EN
        .late_ack_cnt_o(late_ack_cnt_o),
`endif
        .timeout_irq_o (timeout_irq_o),
        .timeout_cnt_o (timeout_cnt_o),
        .last_err_adr_o(last_err_adr_o),
        .last_err_we_o (last_err_we_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        run = 0; blocked = 0; m_cnt = 8'd0; m_late = 8'd0;
        m_irq = 0; m_adr = 32'd0; m_we = 0;
    endtask

    function automatic logic [7:0] sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : 8'(v + 8'd1);
    endfunction

    task automatic drive(input logic s, input logic c, input logic w, input logic [31:0] a,
                         input logic k, input logic [31:0] d, input logic cl);
        stb = s; cyc = c; we = w; adr = a; sack = k; sdat = d; clr = cl;
    endtask

    // Compare DUT outputs with the model at the falling edge.
    task automatic eval();
        logic e_ack, e_stb, chk_dat;
        logic [31:0] e_dat;
        @(negedge clk);
        if (!rst_n) model_reset();
        chk_dat = 1'b1;
        if (!rst_n) begin
            e_ack = 1'b0; e_stb = 1'b0; e_dat = 32'd0;
        end else if (!blocked && run == TO) begin
            e_ack = 1'b1; e_stb = 1'b0; e_dat = ERRD;
        end else if (blocked) begin
            e_ack = 1'b0; e_stb = 1'b0; e_dat = 32'd0; chk_dat = 1'b0;
        end else begin
            e_ack = sack; e_stb = stb & cyc; e_dat = sdat;
        end
        chk("m_ack", 32'(wbs_ack_o), 32'(e_ack));
        chk("m_slv_stb", 32'(slv_stb_o), 32'(e_stb));
        if (chk_dat) chk("m_dat", wbs_dat_o, e_dat);
        chk("m_irq", 32'(timeout_irq_o), 32'(m_irq));
        chk("m_cnt", 32'(timeout_cnt_o), 32'(m_cnt));
        chk("m_adr", last_err_adr_o, m_adr);
        chk("m_we", 32'(last_err_we_o), 32'(m_we));
`ifdef WB_WDOG_LATE_ACK_CNT_EN
        chk("m_late", 32'(late_ack_cnt_o), 32'(m_late));
`endif
    endtask

    // Advance the model across the rising edge, then release inputs for change.
    task automatic adv();
        bit req, err_now;
        @(posedge clk);
        req     = stb & cyc;
        err_now = !blocked && run == TO;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (blocked && sack) m_late = clr ? 8'd1 : sat8(m_late);
            else if (clr)        m_late = 8'd0;
            if (err_now) begin
                blocked = 1; run = 0; m_irq = 1;
                m_cnt = clr ? 8'd1 : sat8(m_cnt);
                m_adr = adr; m_we = we;
            end else begin
                if (clr) begin m_irq = 0; m_cnt = 8'd0; end
                if (blocked) begin
                    if (!req) blocked = 0;
                end else if (run == 0) begin
                    if (req && !sack) run = 1;
                end else if (sack || !cyc) begin
                    run = 0;
                end else begin
                    run++;
                end
            end
        end
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic idle(input logic cl);
        drive(0, 0, 0, 32'd0, 0, 32'd0, cl);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(1, 1, 0, 32'h3000_0000, 1, 32'h5555_5555, 0);
        // Reset: outputs forced low even with a live request and slave ack.
        eval();
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_slv_stb", 32'(slv_stb_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_cnt", 32'(timeout_cnt_o), 32'd0);
        chk("rst_irq", 32'(timeout_irq_o), 32'd0);
        adv();
        step();
        rst_n = 1'b1;
        idle(0);
        step(); step();

        // Read acked on strobe cycle 2.
        drive(1, 1, 0, 32'h3000_0004, 0, 32'd0, 0);
        step();
        drive(1, 1, 0, 32'h3000_0004, 1, 32'h1234_5678, 0);
        eval();
        chk("t1_ack", 32'(wbs_ack_o), 32'd1);
        chk("t1_dat", wbs_dat_o, 32'h1234_5678);
        adv();
        idle(0);
        eval();
        chk("t1_irq", 32'(timeout_irq_o), 32'd0);
        chk("t1_cnt", 32'(timeout_cnt_o), 32'd0);
        adv();

        // Master abort on strobe cycle 3.
        drive(1, 1, 0, 32'h3002_0000, 0, 32'd0, 0);
        step(); step();
        idle(0);
        eval();
        chk("t4_ack", 32'(wbs_ack_o), 32'd0);
        adv();
        eval();
        chk("t4_ack2", 32'(wbs_ack_o), 32'd0);
        chk("t4_irq", 32'(timeout_irq_o), 32'd0);
        adv();

        // Slave acks on the last allowed strobe cycle (4): normal ack.
        drive(1, 1, 0, 32'h3004_0000, 0, 32'd0, 0);
        for (int i = 1; i <= 3; i++) step();
        drive(1, 1, 0, 32'h3004_0000, 1, 32'hCAFE_F00D, 0);
        eval();
        chk("t3_ack", 32'(wbs_ack_o), 32'd1);
        chk("t3_dat", wbs_dat_o, 32'hCAFE_F00D);
        adv();
        idle(0);
        eval();
        chk("t3_cnt", 32'(timeout_cnt_o), 32'd0);
        chk("t3_irq", 32'(timeout_irq_o), 32'd0);
        adv();

        // Read that is never acked: error ack on strobe cycle 5.
        drive(1, 1, 0, 32'h3001_0000, 0, 32'h7777_7777, 0);
        for (int i = 1; i <= 4; i++) begin
            eval();
            chk("t2_noack", 32'(wbs_ack_o), 32'd0);
            adv();
        end
        eval();
        chk("t2_ack", 32'(wbs_ack_o), 32'd1);
        chk("t2_dat", wbs_dat_o, 32'hDEAD_BEEF);
        chk("t2_slv_stb", 32'(slv_stb_o), 32'd0);
        adv();
        idle(0);
        eval();
        chk("t2_irq", 32'(timeout_irq_o), 32'd1);
        chk("t2_cnt", 32'(timeout_cnt_o), 32'd1);
        chk("t2_adr", last_err_adr_o, 32'h3001_0000);
        chk("t2_we", 32'(last_err_we_o), 32'd0);
        adv();

        // Timeout, then a late slave ack during DRAIN with stb still high.
        drive(1, 1, 0, 32'h3003_0000, 0, 32'd0, 0);
        for (int i = 1; i <= 5; i++) step();
        drive(1, 1, 0, 32'h3003_0000, 1, 32'h0BAD_0BAD, 0);
        eval();
        chk("t5_ack", 32'(wbs_ack_o), 32'd0);
        chk("t5_slv_stb", 32'(slv_stb_o), 32'd0);
        adv();
        drive(1, 1, 0, 32'h3003_0000, 0, 32'd0, 0);
        eval();
        chk("t5_ack2", 32'(wbs_ack_o), 32'd0);
`ifdef WB_WDOG_LATE_ACK_CNT_EN
        chk("t5_late", 32'(late_ack_cnt_o), 32'd1);
`endif
        adv();
        idle(0);
        step();

        // 256 timed-out writes: count saturates.
        for (int k = 0; k < 256; k++) begin
            drive(1, 1, 1, 32'h3100_0000 + 32'(k * 4), 0, 32'd0, 0);
            for (int i = 1; i <= 5; i++) step();
            idle(0);
            step();
        end
        eval();
        chk("t6_cnt", 32'(timeout_cnt_o), 32'd255);
        chk("t6_we", 32'(last_err_we_o), 32'd1);
        chk("t6_adr", last_err_adr_o, 32'h3100_03FC);
        adv();

        // Clear pulse.
        idle(1);
        step();
        idle(0);
        eval();
        chk("t7_cnt", 32'(timeout_cnt_o), 32'd0);
        chk("t7_irq", 32'(timeout_irq_o), 32'd0);
        chk("t7_adr_kept", last_err_adr_o, 32'h3100_03FC);
        adv();

        // Clear coincident with an error ack: the error wins.
        drive(1, 1, 0, 32'h3005_0000, 0, 32'd0, 0);
        for (int i = 1; i <= 4; i++) step();
        drive(1, 1, 0, 32'h3005_0000, 0, 32'd0, 1);
        step();
        idle(0);
        eval();
        chk("t8_cnt", 32'(timeout_cnt_o), 32'd1);
        chk("t8_irq", 32'(timeout_irq_o), 32'd1);
        adv();

        // Reset asserted in the middle of a transaction.
        drive(1, 1, 0, 32'h3006_0000, 0, 32'd0, 0);
        step(); step();
        #2 rst_n = 1'b0;
        eval();
        chk("t9_ack", 32'(wbs_ack_o), 32'd0);
        chk("t9_slv_stb", 32'(slv_stb_o), 32'd0);
        chk("t9_irq", 32'(timeout_irq_o), 32'd0);
        chk("t9_cnt", 32'(timeout_cnt_o), 32'd0);
        chk("t9_adr", last_err_adr_o, 32'd0);
        adv();
        rst_n = 1'b1;
        idle(0);
        step();
        // New request after reset starts a fresh transaction.
        drive(1, 1, 0, 32'h3007_0000, 1, 32'hA5A5_5A5A, 0);
        eval();
        chk("t9_post_ack", 32'(wbs_ack_o), 32'd1);
        adv();
        idle(0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_bus_watchdog.md
Name: wb_bus_watchdog

Overview:
- Sits directly upstream of the Wishbone interconnect, between the Caravel Wishbone master port and the interconnect's stb/ack/dat path.
- Passes transactions through combinationally.
- If the addressed slave does not ack within TIMEOUT_CYCLES, it terminates the cycle itself with an error ack and ERR_DATA, so a dead or unmapped team slot cannot hang the management core.
- Records the failing address and a saturating timeout count, and raises a sticky interrupt.

Parameters:
- TIMEOUT_CYCLES, 255: unacked strobe cycles allowed before the watchdog acks; legal range 2..65535.
- CNT_W, 16: width of the internal wait counter; must hold TIMEOUT_CYCLES.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a watchdog ack.

Ports:
- wb_clk_i  in  1  Wishbone clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- wbs_stb_i  in  1  master strobe.
- wbs_cyc_i  in  1  master cycle.
- wbs_we_i  in  1  master write enable; captured on error only.
- wbs_adr_i  in  32  master address.
- wbs_ack_o  out  1  ack to master.
- wbs_dat_o  out  32  read data to master.
- slv_stb_o  out  1  strobe to interconnect.
- slv_ack_i  in  1  ack from interconnect.
- slv_dat_i  in  32  read data from interconnect.
- clr_i  in  1  synchronous clear of irq and count.
- timeout_irq_o  out  1  sticky timeout flag.
- timeout_cnt_o  out  8  saturating timeout count.
- last_err_adr_o  out  32  address of the most recent timed-out access.
- last_err_we_o  out  1  we of the most recent timed-out access.

Behaviour:
- Reset (wb_rst_ni low, async) values:
  - state IDLE, wait counter 0.
  - timeout_irq_o 0, timeout_cnt_o 0.
  - last_err_adr_o 0, last_err_we_o 0.
  - wbs_ack_o 0, wbs_dat_o 0, slv_stb_o 0.
- Definition: req = wbs_stb_i & wbs_cyc_i.
- IDLE / WAIT (pass-through):
  - slv_stb_o = req.
  - wbs_ack_o = slv_ack_i.
  - wbs_dat_o = slv_dat_i.
  - Zero added latency.
- IDLE:
  - req & !slv_ack_i -> WAIT, counter = 1.
  - req & slv_ack_i -> stay IDLE; single-cycle slave.
- WAIT:
  - slv_ack_i -> IDLE, counter = 0.
  - !wbs_cyc_i -> IDLE, no error (master abort).
  - else counter+1. When counter == TIMEOUT_CYCLES with no ack -> ERR_ACK.
- ERR_ACK (exactly 1 cycle):
  - wbs_ack_o = 1, wbs_dat_o = ERR_DATA, slv_stb_o = 0.
  - On exit: latch last_err_adr_o/last_err_we_o from the current wbs_adr_i/wbs_we_i; timeout_cnt_o +1 saturating at 255; timeout_irq_o = 1.
  - Next state: DRAIN.
- DRAIN:
  - slv_stb_o = 0, wbs_ack_o = 0; slv_ack_i ignored (late ack never reaches the master).
  - Stays in DRAIN while req is high; -> IDLE the first cycle req is low.
  - Minimum one DRAIN cycle, so a back-to-back new request is delayed by one cycle.
- Ack timing:
  - A transaction never acked by the slave sees wbs_ack_o high on its (TIMEOUT_CYCLES+1)th strobe cycle.
  - A slave ack on the same cycle the counter reaches TIMEOUT_CYCLES wins: normal ack, no error.
- clr_i:
  - Clears timeout_irq_o and timeout_cnt_o next edge.
  - If coincident with an ERR_ACK exit, the error wins: cnt = 1, irq = 1.
  - last_err_* are not cleared by clr_i.
- Reset mid-transaction: returns to IDLE immediately; any in-flight cycle is dropped without ack.

Optional Feature:
- Macro: WB_WDOG_LATE_ACK_CNT_EN.
- Defined:
  - Adds output late_ack_cnt_o [7:0], reset 0.
  - Increments, saturating at 255, on each slv_ack_i seen in DRAIN.
  - Cleared by clr_i; a coincident late ack wins, giving 1.
- Undefined: port absent; DRAIN acks silently discarded.

Test Plan (bench uses TIMEOUT_CYCLES=4, ERR_DATA=32'hDEAD_BEEF):
- Read 0x3000_0004, slave acks on strobe cycle 2 with 0x1234_5678 -> wbs_ack_o on cycle 2, dat 0x1234_5678, irq 0, cnt 0.
- Read 0x3001_0000, slave never acks -> wbs_ack_o on strobe cycle 5, dat 0xDEAD_BEEF; next cycle irq 1, cnt 1, last_err_adr_o 0x3001_0000, last_err_we_o 0.
- Slave acks exactly on strobe cycle 4 -> normal ack with slave data, no error, cnt unchanged.
- Master drops cyc on strobe cycle 3 with no ack -> IDLE, no ack, irq stays 0.
- Timeout, then slave acks late in DRAIN with stb still high -> wbs_ack_o stays 0; with WB_WDOG_LATE_ACK_CNT_EN, late_ack_cnt_o = 1.
- 256 consecutive timed-out writes -> cnt saturates at 255, last_err_we_o 1. clr_i pulse -> cnt 0, irq 0. clr_i coincident with a new timeout -> cnt 1, irq 1.
